writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/rr_priority_picker.sv | 63 ++++++
 rtl/writeback_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared defaults and types for the writeback arbiter
//
// Purpose : default geometry of the writeback arbiter, the requester-index
//           type and the width/ceiling of the conflict counter.
// Ports   : none (package).
// Config  : WB_ARB_ROUND_ROBIN_EN selects round-robin versus fixed priority
//           in writeback_arbiter; nothing in this package depends on it.

package wb_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    // Requester indices are always two bits wide so that grantIndex has a
    // fixed port width across the whole legal NUM_REQ range (2..4).
    localparam int REQ_IDX_W = 2;
    typedef logic [REQ_IDX_W-1:0] reqIdx_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate-and-pick grant selection
//
// Purpose : choose the highest-priority active request, where priority
//           starts at pointer+1 and wraps modulo NUM_REQ.
// Ports   : request  in  NUM_REQ  active request vector
//           pointer  in  2        last granted index (priority base)
//           grant    out NUM_REQ  one-hot grant, zero when no request
//           index    out 2        index of the granted requester (0 if none)

module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [1:0]         pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         index
);

    // The wrap is split into two scans instead of a modulo: requesters above
    // the pointer come first (lowest of them wins), otherwise the lowest
    // requester at or below the pointer wins.
    logic    hiFound;
    logic    loFound;
    reqIdx_t hiIdx;
    reqIdx_t loIdx;

    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (request[i]) begin
                if (reqIdx_t'(i) > pointer) begin
                    if (!hiFound) begin
                        hiFound = 1'b1;
                        hiIdx   = reqIdx_t'(i);
                    end
                end else begin
                    if (!loFound) begin
                        loFound = 1'b1;
                        loIdx   = reqIdx_t'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        index = '0;
        if (hiFound) begin
            index = hiIdx;
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << hiIdx;
        end else if (loFound) begin
            index = loIdx;
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << loIdx;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file writeback port arbiter
//
// Purpose : arbitrates NUM_REQ writeback requesters onto a single registered
//           register-file write port. Writes to address 0 are accepted and
//           dropped. Counts cycles in which two or more requesters compete.
// Config  : WB_ARB_ROUND_ROBIN_EN defined   -> round-robin priority
//           WB_ARB_ROUND_ROBIN_EN undefined -> fixed priority, index 0 first
// Ports   : clock           in   rising-edge clock
//           reset           in   asynchronous active-low reset
//           freeze          in   debug pause, blocks new grants
//           reqValid        in   NUM_REQ        write requests
//           reqReady        out  NUM_REQ        grant (one-hot or zero)
//           reqAddress      in   NUM_REQ*ADDR_W packed addresses, slice i
//           reqData         in   NUM_REQ*DATA_W packed data, slice i
//           rfWriteEnabled  out  1              registered write enable
//           rfWriteAddress  out  ADDR_W         registered write address
//           rfWriteData     out  DATA_W         registered write data
//           grantIndex      out  2              current grant, holds when idle
//           conflictCount   out  16             saturating conflict counter

module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      freeze,
    input  logic [NUM_REQ-1:0]        reqValid,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddress,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic                      rfWriteEnabled,
    output logic [ADDR_W-1:0]         rfWriteAddress,
    output logic [DATA_W-1:0]         rfWriteData,
    output logic [1:0]                grantIndex,
    output logic [CNT_W-1:0]          conflictCount
);

    localparam reqIdx_t LAST_IDX = reqIdx_t'(NUM_REQ - 1);

    reqIdx_t             pointer;
    reqIdx_t             grantHold;
    logic [NUM_REQ-1:0]  pickGrant;
    reqIdx_t             pickIdx;
    logic                handshake;
    logic                conflict;
    logic [ADDR_W-1:0]   selAddress;
    logic [DATA_W-1:0]   selData;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) picker (
        .request (reqValid),
        .pointer (pointer),
        .grant   (pickGrant),
        .index   (pickIdx)
    );

    // No grants while frozen or while reset is held, so nothing can be
    // accepted that the reset is about to throw away.
    assign reqReady   = (freeze || !reset) ? '0 : pickGrant;
    assign handshake  = |(reqValid & reqReady);
    assign conflict   = !freeze && ($countones(reqValid) > 1);
    assign grantIndex = handshake ? pickIdx : grantHold;

    always_comb begin
        selAddress = '0;
        selData    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickGrant[i]) begin
                selAddress = reqAddress[i*ADDR_W +: ADDR_W];
                selData    = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Pointer holds the last granted index; it starts at NUM_REQ-1 so that
    // requester 0 has first priority after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pointer <= LAST_IDX;
        end else if (handshake) begin
            pointer <= pickIdx;
        end
    end
`else
    // A fixed pointer at NUM_REQ-1 makes the picker scan 0,1,..,NUM_REQ-1,
    // i.e. plain lowest-index-wins priority.
    assign pointer = LAST_IDX;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grantHold <= '0;
        end else if (handshake) begin
            grantHold <= pickIdx;
        end
    end

    // Address 0 is a hardwired-zero register: the handshake completes but
    // the write enable is suppressed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rfWriteEnabled <= 1'b0;
            rfWriteAddress <= '0;
            rfWriteData    <= '0;
        end else if (handshake) begin
            rfWriteEnabled <= (selAddress != '0);
            rfWriteAddress <= selAddress;
            rfWriteData    <= selData;
        end else begin
            rfWriteEnabled <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflictCount <= '0;
        end else if (conflict && (conflictCount != CNT_MAX)) begin
            conflictCount <= conflictCount + 1'b1;
        end
    end

endmodule
